// File: rtl/nor_func_sweeper_if.sv
// nor_func_sweeper_if: operand/result handshake bundle for the NOR-netlist checker.
// The master side supplies operands and consumes results; the slave side is the
// checker itself.
interface nor_func_sweeper_if #(
    parameter int WIDTH = 4
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic [WIDTH-1:0] in_c;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_f;
    logic             out_mismatch;

    modport master (
        output in_valid, in_a, in_b, in_c, out_ready,
        input  in_ready, out_valid, out_f, out_mismatch
    );

    modport slave (
        input  in_valid, in_a, in_b, in_c, out_ready,
        output in_ready, out_valid, out_f, out_mismatch
    );
endinterface

// File: rtl/nor_func_sweeper.sv
// nor_func_sweeper: two-stage pipelined evaluator of F = A & (B | C), computed both
// directly (golden) and through a three-level NOR netlist, flagging any lane where
// the two disagree. A sweep mode feeds every {A,B,C} combination through the same
// pipeline and counts mismatching results.
// Optional feature macro: FAULT_INJECT_EN adds fault_inj_i, which forces lane-0 w2
// low so the netlist output of that lane collapses to A0.
module nor_func_sweeper #(
    parameter int WIDTH = 4,
    parameter int ERRW  = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    nor_func_sweeper_if.slave      bus,
    input  logic                   mode_i,
    input  logic                   start_i,
`ifdef FAULT_INJECT_EN
    input  logic                   fault_inj_i,
`endif
    output logic                   busy_o,
    output logic                   done_o,
    output logic [ERRW-1:0]        err_count_o
);

    localparam int CNTW = 3 * WIDTH;
    localparam logic [CNTW-1:0] CNT_LAST = '1;
    localparam logic [ERRW-1:0] ERR_MAX  = '1;

    typedef enum logic [1:0] {IDLE, SWEEP, DRAIN} state_t;

    state_t            state_q, state_d;
    logic [CNTW-1:0]   cnt_q;
    logic [ERRW-1:0]   err_count_q;

    logic              s1_valid_q;
    logic [WIDTH-1:0]  s1_a_q, s1_b_q, s1_c_q;

    logic              out_valid_q;
    logic [WIDTH-1:0]  out_f_q;
    logic              out_mis_q;

    logic              s2_adv;
    logic              s1_can;
    logic              s1_load;
    logic              sweep_start;
    logic              out_hs;

    logic              src_valid;
    logic [WIDTH-1:0]  src_a, src_b, src_c;

    logic [WIDTH-1:0]  w1, w2, net_f, gold_f;
    logic              net_mis;

    // Pipeline flow control: S2 moves when empty or drained, S1 moves when S2 makes room.
    always_comb begin
        s2_adv  = !out_valid_q || bus.out_ready;
        s1_can  = !s1_valid_q || s2_adv;
        s1_load = src_valid && s1_can;
        out_hs  = out_valid_q && bus.out_ready;
    end

    // Operand source: the sweep counter while sweeping, the external port while idle.
    always_comb begin
        src_valid = 1'b0;
        src_a     = bus.in_a;
        src_b     = bus.in_b;
        src_c     = bus.in_c;
        if (state_q == SWEEP) begin
            src_valid               = 1'b1;
            {src_a, src_b, src_c}   = cnt_q;
        end else if (state_q == IDLE) begin
            src_valid = bus.in_valid;
        end
    end

    // Evaluate the S1 operands both ways; the netlist uses only NOR gates.
    always_comb begin
        w1 = ~(s1_a_q | s1_a_q);
        w2 = ~(s1_b_q | s1_c_q);
`ifdef FAULT_INJECT_EN
        if (fault_inj_i) begin
            w2[0] = 1'b0;
        end
`endif
        net_f   = ~(w1 | w2);
        gold_f  = s1_a_q & (s1_b_q | s1_c_q);
        net_mis = |(net_f ^ gold_f);
    end

    // Sequencer next state: start a sweep, leave it after the last vector, finish when drained.
    always_comb begin
        state_d     = state_q;
        done_o      = 1'b0;
        sweep_start = 1'b0;
        case (state_q)
            IDLE: begin
                if (start_i && mode_i) begin
                    state_d     = SWEEP;
                    sweep_start = 1'b1;
                end
            end
            SWEEP: begin
                if (s1_load && (cnt_q == CNT_LAST)) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (!s1_valid_q && !out_valid_q) begin
                    state_d = IDLE;
                    done_o  = !rst;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Sequencer state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Stage 1 captures operands whenever it can accept a new one.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_q <= 1'b0;
            s1_a_q     <= '0;
            s1_b_q     <= '0;
            s1_c_q     <= '0;
        end else if (s1_can) begin
            s1_valid_q <= s1_load;
            if (s1_load) begin
                s1_a_q <= src_a;
                s1_b_q <= src_b;
                s1_c_q <= src_c;
            end
        end
    end

    // Stage 2 holds the result steady until it is handshaken.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            out_f_q     <= '0;
            out_mis_q   <= 1'b0;
        end else if (s2_adv) begin
            out_valid_q <= s1_valid_q;
            if (s1_valid_q) begin
                out_f_q   <= net_f;
                out_mis_q <= net_mis;
            end
        end
    end

    // Sweep vector counter, restarted by each new sweep.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (sweep_start) begin
            cnt_q <= '0;
        end else if ((state_q == SWEEP) && s1_load) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    // Saturating count of mismatching results consumed since the last sweep start.
    always_ff @(posedge clk) begin
        if (rst) begin
            err_count_q <= '0;
        end else if (sweep_start) begin
            err_count_q <= '0;
        end else if (out_hs && out_mis_q && (err_count_q != ERR_MAX)) begin
            err_count_q <= err_count_q + 1'b1;
        end
    end

    assign bus.in_ready     = !rst && (state_q == IDLE) && s1_can;
    assign bus.out_valid    = out_valid_q;
    assign bus.out_f        = out_f_q;
    assign bus.out_mismatch = out_mis_q && out_valid_q;
    assign busy_o           = (state_q != IDLE);
    assign err_count_o      = err_count_q;

endmodule

// File: tb/tb_nor_func_sweeper.sv
// tb_nor_func_sweeper: scoreboard bench for nor_func_sweeper. A WIDTH=4 instance
// exercises the external operand path; a WIDTH=2 instance exercises sweeps, reset
// abort and ignored controls.
module tb_nor_func_sweeper;

    logic clk = 1'b0;
    logic rst = 1'b1;

    logic        mode4, start4, busy4, done4;
    logic [15:0] err4;
    logic        mode2, start2, busy2, done2;
    logic [15:0] err2;
    logic        fault2;
    bit          faultOn;

    int nCompared   = 0;
    int nMismatched = 0;
    int hs4 = 0;
    int hs2 = 0;

    logic [4:0] sb4[$];
    logic [2:0] sb2[$];

    nor_func_sweeper_if #(.WIDTH(4)) bus4();
    nor_func_sweeper_if #(.WIDTH(2)) bus2();

    nor_func_sweeper #(.WIDTH(4), .ERRW(16)) u4 (
        .clk         (clk),
        .rst         (rst),
        .bus         (bus4),
        .mode_i      (mode4),
        .start_i     (start4),
`ifdef FAULT_INJECT_EN
        .fault_inj_i (1'b0),
`endif
        .busy_o      (busy4),
        .done_o      (done4),
        .err_count_o (err4)
    );

    nor_func_sweeper #(.WIDTH(2), .ERRW(16)) u2 (
        .clk         (clk),
        .rst         (rst),
        .bus         (bus2),
        .mode_i      (mode2),
        .start_i     (start2),
`ifdef FAULT_INJECT_EN
        .fault_inj_i (fault2),
`endif
        .busy_o      (busy2),
        .done_o      (done2),
        .err_count_o (err2)
    );

    always #5 clk = ~clk;

    // Count a comparison and report it if the observed value differs from the expected one.
    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        nCompared++;
        if (actual !== expected) begin
            nMismatched++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, actual, expected);
        end
    endtask

    // Drive one external operand on the WIDTH=4 instance and hold it until accepted.
    task automatic applyStimulus(input logic [3:0] a, input logic [3:0] b, input logic [3:0] c);
        int guard;
        guard = 0;
        bus4.in_valid = 1'b1;
        bus4.in_a     = a;
        bus4.in_b     = b;
        bus4.in_c     = c;
        sb4.push_back({a & (b | c), 1'b0});
        @(negedge clk);
        while (!bus4.in_ready && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        checkOutput("ext_accept", {31'd0, bus4.in_ready}, 32'd1);
        @(posedge clk);
        #1;
        bus4.in_valid = 1'b0;
    endtask

    // Queue the expected result of every sweep vector for the WIDTH=2 instance.
    task automatic pushSweepModel();
        logic [5:0] vec;
        logic [1:0] a, b, c, gold, fExp;
        for (int v = 0; v < 64; v++) begin
            vec  = v[5:0];
            a    = vec[5:4];
            b    = vec[3:2];
            c    = vec[1:0];
            gold = a & (b | c);
            fExp = gold;
            if (faultOn) begin
                fExp[0] = a[0];
            end
            sb2.push_back({fExp, (fExp != gold)});
        end
    endtask

    // Run a full sweep on the WIDTH=2 instance, optionally poking start/in_valid mid-sweep.
    task automatic runSweep(input bit disturb, input int expErr);
        int doneSeen;
        int doneAt;
        doneSeen = 0;
        doneAt   = -1;
        hs2      = 0;
        pushSweepModel();
        @(posedge clk);
        #1;
        start2 = 1'b1;
        mode2  = 1'b1;
        @(posedge clk);
        #1;
        start2 = 1'b0;
        mode2  = 1'b0;
        for (int n = 0; n < 200; n++) begin
            @(negedge clk);
            if (n == 0) begin
                checkOutput("sw_busy_rise", {31'd0, busy2}, 32'd1);
            end
            if (done2) begin
                doneSeen++;
                doneAt = n;
            end
            if (disturb) begin
                if (n == 10) begin
                    start2        = 1'b1;
                    mode2         = 1'b1;
                    bus2.in_valid = 1'b1;
                    bus2.in_a     = 2'b11;
                    bus2.in_b     = 2'b11;
                    bus2.in_c     = 2'b11;
                end
                if (n == 12) begin
                    start2 = 1'b0;
                    mode2  = 1'b0;
                end
                if (n == 40) begin
                    bus2.in_valid = 1'b0;
                end
            end
            if (doneSeen > 0 && n >= doneAt + 3) begin
                break;
            end
        end
        checkOutput("sw_done_count", doneSeen, 1);
        checkOutput("sw_done_cycle", doneAt, 66);
        checkOutput("sw_handshakes", hs2, 64);
        checkOutput("sw_sb_empty", sb2.size(), 0);
        checkOutput("sw_err_count", {16'd0, err2}, expErr);
        checkOutput("sw_busy_after", {31'd0, busy2}, 32'd0);
    endtask

    // Scoreboard for the WIDTH=4 instance: compare every result handshake.
    always @(negedge clk) begin
        if (!rst && bus4.out_valid && bus4.out_ready) begin
            checkOutput("sb4_nonempty", {31'd0, (sb4.size() > 0)}, 32'd1);
            if (sb4.size() > 0) begin
                checkOutput("out4_f_mis", {27'd0, bus4.out_f, bus4.out_mismatch}, {27'd0, sb4.pop_front()});
                hs4++;
            end
        end
    end

    // Scoreboard for the WIDTH=2 instance: compare every result handshake.
    always @(negedge clk) begin
        if (!rst && bus2.out_valid && bus2.out_ready) begin
            checkOutput("sb2_nonempty", {31'd0, (sb2.size() > 0)}, 32'd1);
            if (sb2.size() > 0) begin
                checkOutput("out2_f_mis", {29'd0, bus2.out_f, bus2.out_mismatch}, {29'd0, sb2.pop_front()});
                hs2++;
            end
        end
    end

    // Keep the run bounded even if the design stalls.
    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    // Main sequence.
    initial begin
        int doneCnt;
        logic [3:0] ra, rb, rc;
        bus4.in_valid = 1'b0; bus4.in_a = '0; bus4.in_b = '0; bus4.in_c = '0; bus4.out_ready = 1'b0;
        bus2.in_valid = 1'b0; bus2.in_a = '0; bus2.in_b = '0; bus2.in_c = '0; bus2.out_ready = 1'b0;
        mode4 = 1'b0; start4 = 1'b0; mode2 = 1'b0; start2 = 1'b0;
        fault2 = 1'b0; faultOn = 1'b0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        checkOutput("rst_in_ready_low", {31'd0, bus4.in_ready}, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        checkOutput("rst_in_ready", {31'd0, bus4.in_ready}, 32'd1);
        checkOutput("rst_out_valid", {31'd0, bus4.out_valid}, 32'd0);
        checkOutput("rst_out_f", {28'd0, bus4.out_f}, 32'd0);
        checkOutput("rst_mismatch", {31'd0, bus4.out_mismatch}, 32'd0);
        checkOutput("rst_busy", {31'd0, busy4}, 32'd0);
        checkOutput("rst_done", {31'd0, done4}, 32'd0);
        checkOutput("rst_err", {16'd0, err4}, 32'd0);

        bus4.out_ready = 1'b1;
        bus2.out_ready = 1'b1;
        @(posedge clk);
        #1;

        $display("[TB] external latency");
        applyStimulus(4'b1010, 4'b0110, 4'b0001);
        @(negedge clk);
        checkOutput("lat_k1_valid", {31'd0, bus4.out_valid}, 32'd0);
        @(negedge clk);
        checkOutput("lat_k2_valid", {31'd0, bus4.out_valid}, 32'd1);
        checkOutput("lat_out_f", {28'd0, bus4.out_f}, 32'h2);
        checkOutput("lat_mismatch", {31'd0, bus4.out_mismatch}, 32'd0);
        @(posedge clk);
        #1;

        $display("[TB] external random operands");
        for (int i = 0; i < 6; i++) begin
            ra = 4'($urandom_range(0, 15));
            rb = 4'($urandom_range(0, 15));
            rc = 4'($urandom_range(0, 15));
            applyStimulus(ra, rb, rc);
        end
        repeat (4) @(posedge clk);
        #1;
        checkOutput("ext_sb_empty", sb4.size(), 0);

        $display("[TB] backpressure");
        hs4 = 0;
        bus4.out_ready = 1'b0;
        applyStimulus(4'b1111, 4'b0011, 4'b0100);
        applyStimulus(4'b0110, 4'b1000, 4'b0001);
        bus4.in_valid = 1'b1;
        bus4.in_a     = 4'b1001;
        bus4.in_b     = 4'b0001;
        bus4.in_c     = 4'b1000;
        @(negedge clk);
        checkOutput("bp_in_ready_low", {31'd0, bus4.in_ready}, 32'd0);
        checkOutput("bp_out_valid", {31'd0, bus4.out_valid}, 32'd1);
        @(posedge clk);
        #1;
        bus4.in_valid  = 1'b0;
        bus4.out_ready = 1'b1;
        applyStimulus(4'b1001, 4'b0001, 4'b1000);
        applyStimulus(4'b1100, 4'b0000, 4'b0110);
        for (int i = 0; i < 20 && sb4.size() != 0; i++) begin
            @(negedge clk);
        end
        repeat (2) @(negedge clk);
        checkOutput("bp_drained", sb4.size(), 0);
        checkOutput("bp_count", hs4, 4);

        $display("[TB] sweep");
        runSweep(1'b0, 0);

`ifdef FAULT_INJECT_EN
        $display("[TB] sweep with fault injection");
        fault2  = 1'b1;
        faultOn = 1'b1;
        runSweep(1'b0, 8);
        fault2  = 1'b0;
        faultOn = 1'b0;
`endif

        $display("[TB] sweep with ignored start and in_valid");
        runSweep(1'b1, 0);

        $display("[TB] reset mid-sweep");
        pushSweepModel();
        @(posedge clk);
        #1;
        start2 = 1'b1;
        mode2  = 1'b1;
        @(posedge clk);
        #1;
        start2 = 1'b0;
        mode2  = 1'b0;
        repeat (20) @(negedge clk);
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        checkOutput("abort_out_valid", {31'd0, bus2.out_valid}, 32'd0);
        checkOutput("abort_out_f", {30'd0, bus2.out_f}, 32'd0);
        checkOutput("abort_mismatch", {31'd0, bus2.out_mismatch}, 32'd0);
        checkOutput("abort_busy", {31'd0, busy2}, 32'd0);
        checkOutput("abort_done", {31'd0, done2}, 32'd0);
        checkOutput("abort_err", {16'd0, err2}, 32'd0);
        checkOutput("abort_in_ready", {31'd0, bus2.in_ready}, 32'd0);
        sb2.delete();
        @(posedge clk);
        #1;
        rst = 1'b0;
        doneCnt = 0;
        for (int i = 0; i < 70; i++) begin
            @(negedge clk);
            if (done2) begin
                doneCnt++;
            end
        end
        checkOutput("abort_no_done", doneCnt, 0);
        checkOutput("abort_idle", {31'd0, busy2}, 32'd0);
        checkOutput("abort_in_ready_back", {31'd0, bus2.in_ready}, 32'd1);

        $display("[TB] full sweep after abort");
        runSweep(1'b0, 0);

        checkOutput("ext_err_final", {16'd0, err4}, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule

// File: doc/nor_func_sweeper.md
# nor_func_sweeper

- Parametrised, pipelined evaluator of F = A·(B+C) over WIDTH-bit operand vectors.
- Computes each bit twice:
  - golden: A & (B | C);
  - three-level NOR netlist: w1 = NOR(A,A), w2 = NOR(B,C), F = NOR(w1,w2).
- Flags any disagreement between the two.
- Adds an exhaustive self-sweep mode that enumerates every {A,B,C} combination and counts mismatches.
- Serves as the reusable checker for the logic-gate lab datapaths.

## Interface
Parameters:
- WIDTH, 4, bit width of each of A, B, C and F; one independent function per bit lane
- ERRW, 16, width of the saturating mismatch counter

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  reset; synchronous and active-high
- mode  in  1  0 = external operands, 1 = sweep; sampled only in IDLE with start
- start  in  1  pulse in IDLE begins a sweep when mode=1; ignored otherwise
- in_valid  in  1  external operand valid
- in_ready  out  1  external operand accept
- in_a, in_b, in_c  in  WIDTH each  external operands
- out_valid  out  1  result valid
- out_ready  in  1  result accept
- out_f  out  WIDTH  NOR-netlist result
- out_mismatch  out  1  OR over lanes of (netlist F XOR golden F), qualified by out_valid
- busy  out  1  high in SWEEP and DRAIN
- done  out  1  one-cycle pulse when a sweep completes
- err_count  out  ERRW  mismatching results since the last start
- fault_inj  in  1  present only with FAULT_INJECT_EN

## Operation
- Two-stage pipeline:
  - S1 registers the operands.
  - S2 registers out_f and out_mismatch.
- Handshakes: a transfer occurs on an edge with valid && ready. Data is held stable while valid && !ready.
- Ready rules:
  - S2 advances when !out_valid || out_ready.
  - S1 accepts when it is empty or S2 advances.
  - in_ready = (state==IDLE) && (S1 can accept).
- FSM states: IDLE, SWEEP, DRAIN.
- IDLE -> SWEEP: start && mode. This also clears err_count and the sweep counter.
- SWEEP:
  - An internal source drives S1 with cnt[3·WIDTH-1:0], packed as {A,B,C} with A in the MSBs.
  - cnt increments on each S1 accept.
  - External in_valid is ignored.
  - Accepting cnt == all-ones -> DRAIN.
- DRAIN: when S1 and S2 are both empty (the last result has been handshaken) -> IDLE, asserting done for that one cycle.
- Sweep results appear on out_* and require out_ready exactly as in external mode; none are dropped.
- Mismatch counting:
  - err_count increments on every output handshake with out_mismatch=1, in either mode.
  - It saturates at 2^ERRW-1 and does not wrap.
- start asserted in SWEEP or DRAIN is ignored.
- mode changes outside IDLE have no effect.

## Timing
- Reset values: in_ready=0 during reset and 1 on the first cycle after; out_valid=0, out_f=0, out_mismatch=0, busy=0, done=0, err_count=0; state=IDLE; pipeline empty.
- Latency: operand accepted at edge k -> out_valid high after edge k+1, i.e. 2 cycles.
- Throughput: 1 result/cycle with out_ready held high.
- Backpressure: with out_ready=0, at most 2 accepted-but-unconsumed operands exist (S1 + S2), after which in_ready=0.
- Simultaneous S2 drain and S1 refill in one cycle are both legal.
- Sweep of N = 2^(3·WIDTH) vectors with out_ready=1: busy rises the cycle after start; done pulses N+2 cycles after busy rises.
- rst mid-sweep: next cycle equals the reset state. The partial sweep is discarded and no done is issued.

## Configuration
- FAULT_INJECT_EN defined:
  - Adds port fault_inj.
  - While fault_inj=1, lane-0 w2 is forced to 0, so lane-0 netlist F = A0.
  - The golden path is unaffected.
- FAULT_INJECT_EN undefined:
  - No fault_inj port.
  - The netlist is always exact, so out_mismatch and err_count remain 0.

## Test plan
- External, WIDTH=4: a=1010, b=0110, c=0001 -> out_f=0010, out_mismatch=0, out_valid exactly 2 cycles after accept.
- Backpressure: stream 4 vectors with out_ready=0 -> in_ready drops after 2 accepts. Raising out_ready -> all 4 results emerge in order with no loss or duplication.
- Sweep, WIDTH=2, out_ready=1 -> 64 output handshakes, out_f matching A&(B|C) for each, done pulse once, err_count=0, busy low afterwards.
- FAULT_INJECT_EN, WIDTH=2, fault_inj=1, sweep -> err_count=8 (vectors with a0=1, b0=0, c0=0).
- rst asserted at sweep vector 20 -> all outputs at reset values next cycle, no done. A new start performs a full 64-vector sweep.
- start pulsed during SWEEP and in_valid driven during SWEEP -> both ignored; sweep count and done timing unchanged.
